zap_btb_assoc: RTL and testbench

ZAP_BTB_ASSOC -- requirements
Module: zap_btb_assoc

---
 rtl/zap_btb_pkg.sv | 47 ++++
 rtl/zap_btb_way_sel.sv | 33 +++
 rtl/zap_btb_assoc.sv | 208 ++++++++++++++++++++
 tb/tb_zap_btb_assoc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/zap_btb_pkg.sv
// Shared types for the set-associative BTB: branch-state encoding, entry layout
// and the 2-bit state-update rule applied on feedback.
package zap_btb_pkg;

    localparam int unsigned MAX_TAG_W = 31;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } br_state_e;

    // Tag is stored zero-extended to the widest tag any legal geometry needs
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic [31:0]          target;
        br_state_e            state;
    } btb_entry_t;

    function automatic logic is_taken(input br_state_e s);
        return (s == WT) || (s == ST);
    endfunction

    function automatic br_state_e next_state(input br_state_e cur, input logic nok);
        br_state_e nxt;
        nxt = SNT;
        if (nok) begin
            case (cur)
                SNT:     nxt = WNT;
                WNT:     nxt = WT;
                WT:      nxt = WNT;
                default: nxt = WT;
            endcase
        end else begin
            case (cur)
                SNT:     nxt = SNT;
                WNT:     nxt = SNT;
                WT:      nxt = ST;
                default: nxt = ST;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/zap_btb_way_sel.sv
// Per-set way selection: lowest-numbered valid tag hit, and allocation victim
// (lowest invalid way, else the set's round-robin pointer).
module zap_btb_way_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned WAY_W = 1
) (
    input  logic [WAYS-1:0]  i_valid,
    input  logic [WAYS-1:0]  i_match,
    input  logic [WAY_W-1:0] i_rr_ptr,
    output logic             o_hit_c,
    output logic [WAY_W-1:0] o_hit_way_c,
    output logic [WAY_W-1:0] o_victim_way_c,
    output logic             o_full_c
);

    // Descending scans so the lowest-numbered candidate is the one that sticks
    always_comb begin
        o_hit_c        = 1'b0;
        o_hit_way_c    = '0;
        o_victim_way_c = i_rr_ptr;
        o_full_c       = &i_valid;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (i_valid[w] && i_match[w]) begin
                o_hit_c     = 1'b1;
                o_hit_way_c = WAY_W'(w);
            end
            if (!i_valid[w]) begin
                o_victim_way_c = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/zap_btb_assoc.sv
// Set-associative branch target buffer with a 2-stage lookup and same-cycle
// feedback update. Optional perf counters behind ZAP_BTB_PERF_EN.
module zap_btb_assoc
    import zap_btb_pkg::*;
#(
    parameter int unsigned BP_ENTRIES = 32'd1024,
    parameter int unsigned BP_WAYS    = 32'd2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_clear,
    input  logic        i_fb_ok,
    input  logic        i_fb_nok,
    input  logic [31:0] i_fb_branch_src_address,
    input  logic [1:0]  i_fb_current_branch_state,
    input  logic [31:0] i_fb_branch_dest_address,
    input  logic [31:0] i_rd_addr,
    output logic        o_clear_from_btb,
    output logic [31:0] o_pc_from_btb,
    output logic [1:0]  o_branch_state
`ifdef ZAP_BTB_PERF_EN
    ,
    output logic [31:0] o_perf_lookups,
    output logic [31:0] o_perf_hits
`endif
);

    localparam int unsigned SETS  = BP_ENTRIES / BP_WAYS;
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 31 - IDX_W;
    localparam int unsigned WAY_W = (BP_WAYS > 1) ? $clog2(BP_WAYS) : 1;

    btb_entry_t           entries_q [SETS][BP_WAYS];
    btb_entry_t           entries_d [SETS][BP_WAYS];
    logic [WAY_W-1:0]     rr_q [SETS];
    logic [WAY_W-1:0]     rr_d [SETS];

    logic                 rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [MAX_TAG_W-1:0] rd_tag_q, rd_tag_d;
    logic                 clear_q, clear_d;
    logic [31:0]          pc_q, pc_d;
    br_state_e            state_q, state_d;

    logic [IDX_W-1:0]     fb_idx;
    logic [MAX_TAG_W-1:0] fb_tag;
    logic                 fb_en;
    logic [BP_WAYS-1:0]   rd_valid_vec, rd_match_vec, fb_valid_vec, fb_match_vec;
    logic                 rd_hit, fb_hit, fb_full;
    logic [WAY_W-1:0]     rd_hit_way, fb_hit_way, fb_victim, fb_way;
    logic [WAY_W-1:0]     rd_victim_unused;
    logic                 rd_full_unused;
    logic                 unused_ok;
    btb_entry_t           rd_hit_entry;
    logic                 rd_taken;

    assign unused_ok = ^{i_rd_addr[0], i_fb_branch_src_address[0]};

    assign fb_idx = i_fb_branch_src_address[IDX_W:1];
    assign fb_tag = MAX_TAG_W'(i_fb_branch_src_address[IDX_W+TAG_W:IDX_W+1]);
    assign fb_en  = i_fb_ok | i_fb_nok;

    // Tag-compare vectors for the registered read set and the feedback set
    always_comb begin
        rd_valid_vec = '0;
        rd_match_vec = '0;
        fb_valid_vec = '0;
        fb_match_vec = '0;
        for (int unsigned w = 0; w < BP_WAYS; w++) begin
            rd_valid_vec[w] = entries_q[rd_idx_q][w].valid;
            rd_match_vec[w] = (entries_q[rd_idx_q][w].tag == rd_tag_q);
            fb_valid_vec[w] = entries_q[fb_idx][w].valid;
            fb_match_vec[w] = (entries_q[fb_idx][w].tag == fb_tag);
        end
    end

    zap_btb_way_sel #(.WAYS(BP_WAYS), .WAY_W(WAY_W)) u_rd_sel (
        .i_valid        (rd_valid_vec),
        .i_match        (rd_match_vec),
        .i_rr_ptr       ('0),
        .o_hit_c        (rd_hit),
        .o_hit_way_c    (rd_hit_way),
        .o_victim_way_c (rd_victim_unused),
        .o_full_c       (rd_full_unused)
    );

    zap_btb_way_sel #(.WAYS(BP_WAYS), .WAY_W(WAY_W)) u_fb_sel (
        .i_valid        (fb_valid_vec),
        .i_match        (fb_match_vec),
        .i_rr_ptr       (rr_q[fb_idx]),
        .o_hit_c        (fb_hit),
        .o_hit_way_c    (fb_hit_way),
        .o_victim_way_c (fb_victim),
        .o_full_c       (fb_full)
    );

    assign fb_way       = fb_hit ? fb_hit_way : fb_victim;
    assign rd_hit_entry = entries_q[rd_idx_q][rd_hit_way];
    assign rd_taken     = rd_vld_q && rd_hit && is_taken(rd_hit_entry.state);

    always_comb begin
        entries_d = entries_q;
        rr_d      = rr_q;
        rd_vld_d  = rd_vld_q;
        rd_idx_d  = rd_idx_q;
        rd_tag_d  = rd_tag_q;
        clear_d   = clear_q;
        pc_d      = pc_q;
        state_d   = state_q;
        if (i_clear) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_d[s] = '0;
                for (int unsigned w = 0; w < BP_WAYS; w++) begin
                    entries_d[s][w].valid = 1'b0;
                end
            end
            rd_vld_d = 1'b0;
            clear_d  = 1'b0;
        end else begin
            if (!i_stall) begin
                rd_vld_d = 1'b1;
                rd_idx_d = i_rd_addr[IDX_W:1];
                rd_tag_d = MAX_TAG_W'(i_rd_addr[IDX_W+TAG_W:IDX_W+1]);
                clear_d  = rd_taken;
                state_d  = (rd_vld_q && rd_hit) ? rd_hit_entry.state : SNT;
                if (rd_taken) begin
                    pc_d = rd_hit_entry.target;
                end
            end
            // Read above uses entries_q, so a same-set write is seen next lookup
            if (fb_en) begin
                entries_d[fb_idx][fb_way].valid  = 1'b1;
                entries_d[fb_idx][fb_way].tag    = fb_tag;
                entries_d[fb_idx][fb_way].target = i_fb_branch_dest_address;
                entries_d[fb_idx][fb_way].state  =
                    next_state(br_state_e'(i_fb_current_branch_state), i_fb_nok);
                if (!fb_hit && fb_full) begin
                    rr_d[fb_idx] = (rr_q[fb_idx] == WAY_W'(BP_WAYS - 1)) ?
                                   '0 : rr_q[fb_idx] + WAY_W'(1);
                end
            end
        end
    end

    // Only valid bits, pointers and output/pipeline state are reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int unsigned w = 0; w < BP_WAYS; w++) begin
                    entries_q[s][w].valid <= 1'b0;
                end
            end
            rd_vld_q <= 1'b0;
            clear_q  <= 1'b0;
            pc_q     <= '0;
            state_q  <= SNT;
        end else begin
            entries_q <= entries_d;
            rr_q      <= rr_d;
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
            rd_tag_q  <= rd_tag_d;
            clear_q   <= clear_d;
            pc_q      <= pc_d;
            state_q   <= state_d;
        end
    end

    assign o_clear_from_btb = clear_q;
    assign o_pc_from_btb    = pc_q;
    assign o_branch_state   = state_q;

`ifdef ZAP_BTB_PERF_EN
    logic [31:0] perf_lookups_q, perf_lookups_d;
    logic [31:0] perf_hits_q, perf_hits_d;
    logic        lookup_fire;

    assign lookup_fire = !i_clear && !i_stall && rd_vld_q;

    // Saturating counters; i_clear intentionally leaves them alone
    always_comb begin
        perf_lookups_d = perf_lookups_q;
        perf_hits_d    = perf_hits_q;
        if (lookup_fire && (perf_lookups_q != '1)) begin
            perf_lookups_d = perf_lookups_q + 32'd1;
        end
        if (lookup_fire && rd_taken && (perf_hits_q != '1)) begin
            perf_hits_d = perf_hits_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            perf_lookups_q <= '0;
            perf_hits_q    <= '0;
        end else begin
            perf_lookups_q <= perf_lookups_d;
            perf_hits_q    <= perf_hits_d;
        end
    end

    assign o_perf_lookups = perf_lookups_q;
    assign o_perf_hits    = perf_hits_q;
`endif

endmodule

// File: tb/tb_zap_btb_assoc.sv
// Directed bench for zap_btb_assoc (1024 entries, 2 ways, 512 sets).
// 0x100 / 0x500 / 0x900 share set 0x80 with tags 0 / 1 / 2.
module tb_zap_btb_assoc;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_fb_ok = 1'b0;
    logic        i_fb_nok = 1'b0;
    logic [31:0] i_fb_branch_src_address = '0;
    logic [1:0]  i_fb_current_branch_state = '0;
    logic [31:0] i_fb_branch_dest_address = '0;
    logic [31:0] i_rd_addr = '0;
    logic        o_clear_from_btb;
    logic [31:0] o_pc_from_btb;
    logic [1:0]  o_branch_state;
`ifdef ZAP_BTB_PERF_EN
    logic [31:0] o_perf_lookups;
    logic [31:0] o_perf_hits;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    zap_btb_assoc #(.BP_ENTRIES(32'd1024), .BP_WAYS(32'd2)) dut (
        .i_clk                     (i_clk),
        .i_reset                   (i_reset),
        .i_stall                   (i_stall),
        .i_clear                   (i_clear),
        .i_fb_ok                   (i_fb_ok),
        .i_fb_nok                  (i_fb_nok),
        .i_fb_branch_src_address   (i_fb_branch_src_address),
        .i_fb_current_branch_state (i_fb_current_branch_state),
        .i_fb_branch_dest_address  (i_fb_branch_dest_address),
        .i_rd_addr                 (i_rd_addr),
        .o_clear_from_btb          (o_clear_from_btb),
        .o_pc_from_btb             (o_pc_from_btb),
        .o_branch_state            (o_branch_state)
`ifdef ZAP_BTB_PERF_EN
        ,
        .o_perf_lookups            (o_perf_lookups),
        .o_perf_hits               (o_perf_hits)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a);
        i_rd_addr = a;
        tick();
        tick();
    endtask

    task automatic feedback(input logic nok, input logic [31:0] src,
                            input logic [1:0] st, input logic [31:0] dst);
        i_fb_nok = nok;
        i_fb_ok  = !nok;
        i_fb_branch_src_address   = src;
        i_fb_current_branch_state = st;
        i_fb_branch_dest_address  = dst;
        tick();
        i_fb_nok = 1'b0;
        i_fb_ok  = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_rd_addr = 32'h100;
        tick();
        tick();
        i_reset = 1'b0;
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL reset_clear got %0b want 0", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_pc_from_btb !== 32'h0) $display("FAIL reset_pc got %h want 0", o_pc_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd0) $display("FAIL reset_state got %0d want 0", o_branch_state); else n_pass++;
        lookup(32'h100);
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL cold_miss_clear got %0b want 0", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd0) $display("FAIL cold_miss_state got %0d want 0", o_branch_state); else n_pass++;
    endtask

    task automatic test_train();
        feedback(1'b1, 32'h100, 2'd1, 32'h800);
        lookup(32'h100);
        n_checks++; if (o_clear_from_btb !== 1'b1) $display("FAIL train_clear got %0b want 1", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_pc_from_btb !== 32'h800) $display("FAIL train_pc got %h want 800", o_pc_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd2) $display("FAIL train_state got %0d want 2", o_branch_state); else n_pass++;
    endtask

    task automatic test_ok_update();
        feedback(1'b0, 32'h100, 2'd2, 32'h800);
        lookup(32'h100);
        n_checks++; if (o_clear_from_btb !== 1'b1) $display("FAIL ok_wt_clear got %0b want 1", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd3) $display("FAIL ok_wt_state got %0d want 3", o_branch_state); else n_pass++;
        feedback(1'b0, 32'h100, 2'd1, 32'h800);
        lookup(32'h100);
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL ok_wnt_clear got %0b want 0", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd0) $display("FAIL ok_wnt_state got %0d want 0", o_branch_state); else n_pass++;
        n_checks++; if (o_pc_from_btb !== 32'h800) $display("FAIL pc_hold got %h want 800", o_pc_from_btb); else n_pass++;
    endtask

    task automatic test_evict();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL clear_out got %0b want 0", o_clear_from_btb); else n_pass++;
        feedback(1'b1, 32'h100, 2'd1, 32'h1000);
        feedback(1'b1, 32'h500, 2'd1, 32'h2000);
        feedback(1'b1, 32'h900, 2'd1, 32'h3000);
        lookup(32'h100);
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL evict_a_clear got %0b want 0", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd0) $display("FAIL evict_a_state got %0d want 0", o_branch_state); else n_pass++;
        lookup(32'h500);
        n_checks++; if (o_clear_from_btb !== 1'b1) $display("FAIL evict_b_clear got %0b want 1", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_pc_from_btb !== 32'h2000) $display("FAIL evict_b_pc got %h want 2000", o_pc_from_btb); else n_pass++;
        lookup(32'h900);
        n_checks++; if (o_clear_from_btb !== 1'b1) $display("FAIL evict_c_clear got %0b want 1", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_pc_from_btb !== 32'h3000) $display("FAIL evict_c_pc got %h want 3000", o_pc_from_btb); else n_pass++;
        // Round-robin pointer now on way 1, so re-adding 0x100 evicts 0x500
        feedback(1'b1, 32'h100, 2'd1, 32'h1000);
        lookup(32'h500);
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL rr_b_clear got %0b want 0", o_clear_from_btb); else n_pass++;
        lookup(32'h100);
        n_checks++; if (o_pc_from_btb !== 32'h1000) $display("FAIL rr_a_pc got %h want 1000", o_pc_from_btb); else n_pass++;
        lookup(32'h900);
        n_checks++; if (o_pc_from_btb !== 32'h3000) $display("FAIL rr_c_pc got %h want 3000", o_pc_from_btb); else n_pass++;
    endtask

    task automatic test_stall();
        lookup(32'h200);
        i_rd_addr = 32'h900;
        tick();
        i_stall = 1'b1;
        i_rd_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL stall_clear[%0d] got %0b want 0", i, o_clear_from_btb); else n_pass++;
            n_checks++; if (o_pc_from_btb !== 32'h3000) $display("FAIL stall_pc[%0d] got %h want 3000", i, o_pc_from_btb); else n_pass++;
        end
        i_stall = 1'b0;
        tick();
        n_checks++; if (o_clear_from_btb !== 1'b1) $display("FAIL unstall_clear got %0b want 1", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd2) $display("FAIL unstall_state got %0d want 2", o_branch_state); else n_pass++;
    endtask

    task automatic test_same_cycle();
        i_rd_addr = 32'h900;
        tick();
        feedback(1'b1, 32'h900, 2'd2, 32'h3000);
        n_checks++; if (o_clear_from_btb !== 1'b1) $display("FAIL rw_old_clear got %0b want 1", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd2) $display("FAIL rw_old_state got %0d want 2", o_branch_state); else n_pass++;
        tick();
        n_checks++; if (o_branch_state !== 2'd1) $display("FAIL rw_new_state got %0d want 1", o_branch_state); else n_pass++;
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL rw_new_clear got %0b want 0", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_pc_from_btb !== 32'h3000) $display("FAIL rw_new_pc got %h want 3000", o_pc_from_btb); else n_pass++;
    endtask

    task automatic test_clear();
        i_rd_addr = 32'h100;
        tick();
        i_clear = 1'b1;
        feedback(1'b1, 32'h500, 2'd1, 32'h4000);
        i_clear = 1'b0;
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL clr_pipe got %0b want 0", o_clear_from_btb); else n_pass++;
        lookup(32'h100);
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL clr_a got %0b want 0", o_clear_from_btb); else n_pass++;
        n_checks++; if (o_branch_state !== 2'd0) $display("FAIL clr_a_state got %0d want 0", o_branch_state); else n_pass++;
        lookup(32'h500);
        n_checks++; if (o_branch_state !== 2'd0) $display("FAIL clr_fb_dropped got %0d want 0", o_branch_state); else n_pass++;
        lookup(32'h900);
        n_checks++; if (o_clear_from_btb !== 1'b0) $display("FAIL clr_c got %0b want 0", o_clear_from_btb); else n_pass++;
    endtask

`ifdef ZAP_BTB_PERF_EN
    task automatic test_perf();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        n_checks++; if (o_perf_lookups !== 32'd0) $display("FAIL perf_rst_lk got %0d want 0", o_perf_lookups); else n_pass++;
        i_rd_addr = 32'h100;
        feedback(1'b1, 32'h100, 2'd1, 32'h800);
        lookup(32'h100);
        n_checks++; if (o_perf_lookups !== 32'd2) $display("FAIL perf_lk got %0d want 2", o_perf_lookups); else n_pass++;
        n_checks++; if (o_perf_hits !== 32'd2) $display("FAIL perf_hit got %0d want 2", o_perf_hits); else n_pass++;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        tick();
        n_checks++; if (o_perf_lookups !== 32'd2) $display("FAIL perf_clr_lk got %0d want 2", o_perf_lookups); else n_pass++;
        n_checks++; if (o_perf_hits !== 32'd2) $display("FAIL perf_clr_hit got %0d want 2", o_perf_hits); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_train();
        test_ok_update();
        test_evict();
        test_stall();
        test_same_cycle();
        test_clear();
`ifdef ZAP_BTB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
